// File: rtl/aes128_decrypt_core_if.sv
// Request/response bundle of the AES-128 decrypt core.
interface aes128_decrypt_core_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         ready;
  logic         valid;
  logic [127:0] plaintext;

  modport master (
    output start, key, ciphertext,
    input  ready, valid, plaintext
  );

  modport slave (
    input  start, key, ciphertext,
    output ready, valid, plaintext
  );
endinterface

// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock. The round-10 key is reached by forward
// expansion, then the schedule is unwound one round key per cycle alongside the data rounds.
module aes128_decrypt_core #(
  parameter bit KEY_CACHE = 1'b1
) (
  input logic                  clk,
  input logic                  reset_n,
  aes128_decrypt_core_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StKeyExp, StInit, StRound, StFinal} state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Tables are packed entry 0 first, so entry x sits at bit offset (255 - x) * 8.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant whose bits select a, 2a, 4a, 8a.
  function automatic logic [7:0] gmul_const(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul_const(a0, 4'he) ^ gmul_const(a1, 4'hb) ^
                             gmul_const(a2, 4'hd) ^ gmul_const(a3, 4'h9);
      o[119 - 32 * c -: 8] = gmul_const(a0, 4'h9) ^ gmul_const(a1, 4'he) ^
                             gmul_const(a2, 4'hb) ^ gmul_const(a3, 4'hd);
      o[111 - 32 * c -: 8] = gmul_const(a0, 4'hd) ^ gmul_const(a1, 4'h9) ^
                             gmul_const(a2, 4'he) ^ gmul_const(a3, 4'hb);
      o[103 - 32 * c -: 8] = gmul_const(a0, 4'hb) ^ gmul_const(a1, 4'hd) ^
                             gmul_const(a2, 4'h9) ^ gmul_const(a3, 4'he);
    end
    return o;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d, k0_q, k0_d, ct_q, ct_d, st_q, st_d, pt_q, pt_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         cache_valid_q, cache_valid_d;
  logic [127:0] cache_key_q, cache_key_d, cache_k10_q, cache_k10_d;

  logic [31:0]  w0, w1, w2, w3, m3, sub_in, sub_out, rc_word, f0, f1, f2, f3;
  logic [127:0] fwd_key, inv_key, inv_sb;

  // Forward and backward key steps never run in the same cycle, so they share one SubWord.
  assign {w0, w1, w2, w3} = rk_q;
  assign rc_word = {rcon((state_q == StInit) ? 4'd10 : cnt_q), 24'h0};
  assign m3      = w3 ^ w2;
  assign sub_in  = (state_q == StKeyExp) ? w3 : m3;
  assign sub_out = sub_word({sub_in[23:0], sub_in[31:24]});
  assign f0      = w0 ^ sub_out ^ rc_word;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
  assign inv_key = {w0 ^ sub_out ^ rc_word, w1 ^ w0, w2 ^ w1, m3};
  assign inv_sb  = inv_sub_bytes(inv_shift_rows(st_q));

  always_comb begin
    state_d       = state_q;
    rk_d          = rk_q;
    k0_d          = k0_q;
    ct_d          = ct_q;
    st_d          = st_q;
    pt_d          = pt_q;
    cnt_d         = cnt_q;
    valid_d       = 1'b0;
    cache_valid_d = cache_valid_q;
    cache_key_d   = cache_key_q;
    cache_k10_d   = cache_k10_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          rk_d = bus.key;
          k0_d = bus.key;
          ct_d = bus.ciphertext;
          if (KEY_CACHE && cache_valid_q && (bus.key == cache_key_q)) begin
            rk_d    = cache_k10_q;
            state_d = StInit;
          end else begin
            cnt_d   = 4'd1;
            state_d = StKeyExp;
          end
        end
      end
      StKeyExp: begin
        rk_d  = fwd_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          if (KEY_CACHE) begin
            cache_key_d   = k0_q;
            cache_k10_d   = fwd_key;
            cache_valid_d = 1'b1;
          end
          state_d = StInit;
        end
      end
      StInit: begin
        st_d    = ct_q ^ rk_q;
        rk_d    = inv_key;
        cnt_d   = 4'd9;
        state_d = StRound;
      end
      StRound: begin
        st_d  = inv_mix_columns(inv_sb ^ rk_q);
        rk_d  = inv_key;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StFinal;
      end
      StFinal: begin
        pt_d    = inv_sb ^ rk_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      rk_q          <= '0;
      k0_q          <= '0;
      ct_q          <= '0;
      st_q          <= '0;
      pt_q          <= '0;
      cnt_q         <= '0;
      valid_q       <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      cache_k10_q   <= '0;
    end else begin
      state_q       <= state_d;
      rk_q          <= rk_d;
      k0_q          <= k0_d;
      ct_q          <= ct_d;
      st_q          <= st_d;
      pt_q          <= pt_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      cache_valid_q <= cache_valid_d;
      cache_key_q   <= cache_key_d;
      cache_k10_q   <= cache_k10_d;
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.valid     = valid_q;
  assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Directed and randomised checks of aes128_decrypt_core with and without the key cache.
module tb_aes128_decrypt_core;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_decrypt_core_if bus ();
  aes128_decrypt_core_if nc_bus ();

  // The cacheless core sees exactly the same requests.
  assign nc_bus.start      = bus.start;
  assign nc_bus.key        = bus.key;
  assign nc_bus.ciphertext = bus.ciphertext;

  aes128_decrypt_core #(.KEY_CACHE(1'b1)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  aes128_decrypt_core #(.KEY_CACHE(1'b0)) dut_nc (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (nc_bus.slave)
  );

  // Reference: forward cipher with an S-box derived from GF(2^8) inversion plus affine map.
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = xt(a);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(x));
      end
      b = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        b = {b[6:0], b[7]};
        s ^= b;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [7:0]   rc = 8'h01;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) n[4 * c + r] = s[4 * ((c + r) % 4) + r];
        s = n;
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
            s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] ^= w[4 * rnd + c][31 - 8 * r -: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Issue one request and watch both cores for 24 cycles after the accept edge.
  task automatic run_op(input logic [127:0] k, input logic [127:0] c, input bit pulse_busy,
                        output logic [127:0] pt, output logic [127:0] pt_nc,
                        output int lat, output int lat_nc, output int nv, output int nv_nc,
                        output int ready_hi);
    pt = '0; pt_nc = '0; lat = -1; lat_nc = -1; nv = 0; nv_nc = 0; ready_hi = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.key = k; bus.ciphertext = c;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.key = ~k; bus.ciphertext = ~c;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.valid) begin
        nv++;
        if (lat < 0) lat = n;
        pt = bus.plaintext;
      end
      if (nc_bus.valid) begin
        nv_nc++;
        if (lat_nc < 0) lat_nc = n;
        pt_nc = nc_bus.plaintext;
      end
      if (pulse_busy) begin
        if (n >= 3 && n <= 15) begin
          if (bus.ready || nc_bus.ready) ready_hi++;
          bus.start = 1'b1; bus.key = K2; bus.ciphertext = C2;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    checks++;
    if (bus.plaintext !== 128'h0) begin
      errors++; $display("FAIL reset_plaintext: got %h expected 0", bus.plaintext);
    end
    checks++;
    if (nc_bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_nc: got %b expected 1", nc_bus.ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fips_c1();
    logic [127:0] pt, pt_nc;
    int lat, lat_nc, nv, nv_nc, rh;
    run_op(K1, C1, 1'b0, pt, pt_nc, lat, lat_nc, nv, nv_nc, rh);
    checks++;
    if (pt !== P1) begin errors++; $display("FAIL c1_plaintext: got %h expected %h", pt, P1); end
    checks++;
    if (lat != 21) begin errors++; $display("FAIL c1_latency: got %0d expected 21", lat); end
    checks++;
    if (nv != 1) begin errors++; $display("FAIL c1_pulse_count: got %0d expected 1", nv); end
    checks++;
    if (pt_nc !== P1) begin
      errors++; $display("FAIL c1_plaintext_nc: got %h expected %h", pt_nc, P1);
    end
    checks++;
    if (lat_nc != 21) begin errors++; $display("FAIL c1_latency_nc: got %0d expected 21", lat_nc); end
  endtask

  task automatic test_fips_b();
    logic [127:0] pt, pt_nc;
    int lat, lat_nc, nv, nv_nc, rh;
    run_op(K2, C2, 1'b0, pt, pt_nc, lat, lat_nc, nv, nv_nc, rh);
    checks++;
    if (pt !== P2) begin errors++; $display("FAIL b_plaintext: got %h expected %h", pt, P2); end
    checks++;
    if (lat != 21) begin errors++; $display("FAIL b_latency: got %0d expected 21", lat); end
    checks++;
    if (pt_nc !== P2) begin
      errors++; $display("FAIL b_plaintext_nc: got %h expected %h", pt_nc, P2);
    end
  endtask

  task automatic test_key_cache();
    logic [127:0] pt, pt_nc;
    int lat, lat_nc, nv, nv_nc, rh;
    run_op(K2, C2, 1'b0, pt, pt_nc, lat, lat_nc, nv, nv_nc, rh);
    checks++;
    if (pt !== P2) begin errors++; $display("FAIL hit_plaintext: got %h expected %h", pt, P2); end
    checks++;
    if (lat != 11) begin errors++; $display("FAIL hit_latency: got %0d expected 11", lat); end
    checks++;
    if (nv != 1) begin errors++; $display("FAIL hit_pulse_count: got %0d expected 1", nv); end
    checks++;
    if (lat_nc != 21) begin errors++; $display("FAIL nocache_latency: got %0d expected 21", lat_nc); end
    checks++;
    if (pt_nc !== P2) begin
      errors++; $display("FAIL nocache_plaintext: got %h expected %h", pt_nc, P2);
    end
    run_op(K1, C1, 1'b0, pt, pt_nc, lat, lat_nc, nv, nv_nc, rh);
    checks++;
    if (pt !== P1) begin errors++; $display("FAIL miss_plaintext: got %h expected %h", pt, P1); end
    checks++;
    if (lat != 21) begin errors++; $display("FAIL miss_latency: got %0d expected 21", lat); end
    checks++;
    if (lat_nc != 21) begin
      errors++; $display("FAIL miss_latency_nc: got %0d expected 21", lat_nc);
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] pt, pt_nc;
    int lat, lat_nc, nv, nv_nc, rh;
    // Clear the cache so the T1 key misses and the core stays busy through the pulses.
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_op(K1, C1, 1'b1, pt, pt_nc, lat, lat_nc, nv, nv_nc, rh);
    checks++;
    if (pt !== P1) begin errors++; $display("FAIL busy_plaintext: got %h expected %h", pt, P1); end
    checks++;
    if (lat != 21) begin errors++; $display("FAIL busy_latency: got %0d expected 21", lat); end
    checks++;
    if (rh != 0) begin errors++; $display("FAIL busy_ready: got %0d ready-high cycles expected 0", rh); end
    checks++;
    if (nv != 1) begin errors++; $display("FAIL busy_pulse_count: got %0d expected 1", nv); end
    checks++;
    if (nv_nc != 1 || pt_nc !== P1) begin
      errors++; $display("FAIL busy_nc: got %0d pulses pt %h expected 1 pulse pt %h", nv_nc, pt_nc, P1);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] pt, pt_nc;
    int lat, lat_nc, nv, nv_nc, rh, late;
    @(negedge clk);
    bus.start = 1'b1; bus.key = K1; bus.ciphertext = C1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", bus.ready); end
    checks++;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bus.valid); end
    checks++;
    if (bus.plaintext !== 128'h0) begin
      errors++; $display("FAIL midreset_plaintext: got %h expected 0", bus.plaintext);
    end
    checks++;
    if (nc_bus.ready !== 1'b1 || nc_bus.plaintext !== 128'h0) begin
      errors++; $display("FAIL midreset_nc: got ready %b pt %h expected 1 and 0", nc_bus.ready,
                         nc_bus.plaintext);
    end
    reset_n = 1'b1;
    late = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid || nc_bus.valid) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL midreset_late_valid: got %0d expected 0", late); end
    run_op(K1, C1, 1'b0, pt, pt_nc, lat, lat_nc, nv, nv_nc, rh);
    checks++;
    if (lat != 21) begin errors++; $display("FAIL postreset_latency: got %0d expected 21", lat); end
    checks++;
    if (pt !== P1) begin errors++; $display("FAIL postreset_plaintext: got %h expected %h", pt, P1); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k, p, c, exp_pt;
    int waited;
    k = rand128(); p = rand128(); c = aes_encrypt(k, p);
    @(negedge clk);
    bus.start = 1'b1; bus.key = k; bus.ciphertext = c; exp_pt = p;
    for (int i = 0; i < 1000; i++) begin
      waited = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        waited++;
      end while (!bus.valid && waited < 40);
      checks++;
      if (!bus.valid) begin
        errors++;
        $display("FAIL b2b_timeout: vector %0d got no valid after %0d cycles expected 22", i, waited);
        bus.start = 1'b0;
        return;
      end
      if (bus.plaintext !== exp_pt) begin
        errors++; $display("FAIL b2b_plaintext: vector %0d got %h expected %h", i, bus.plaintext, exp_pt);
      end
      checks++;
      if (waited != 22) begin
        errors++; $display("FAIL b2b_latency: vector %0d got %0d expected 22", i, waited);
      end
      checks++;
      if (nc_bus.valid !== 1'b1 || nc_bus.plaintext !== exp_pt) begin
        errors++; $display("FAIL b2b_nc: vector %0d got valid %b pt %h expected 1 and %h", i,
                           nc_bus.valid, nc_bus.plaintext, exp_pt);
      end
      if (i < 999) begin
        k = rand128(); p = rand128(); c = aes_encrypt(k, p);
        bus.key = k; bus.ciphertext = c; exp_pt = p;
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.key = '0;
    bus.ciphertext = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_key_cache();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
